// File: rtl/mips_alu_pkg.sv
// Shared MIPS ALU definitions: state encodings, default width and opcodes.
package mips_alu_pkg;

    localparam int MOD_WIDTH = 32;

    localparam logic [3:0] ALU_OP_MOD = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mod_state_t;

endpackage

// File: rtl/mod_step.sv
// One restoring shift-subtract stage of the modulo datapath.
module mod_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic             qbit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next
);

    logic [WIDTH-1:0] t;
    logic [WIDTH:0]   t_wide;
    logic             ge;

    // The shifted-out MSB of r makes the trial value WIDTH+1 bits wide.
    assign t      = {r[WIDTH-2:0], qbit};
    assign t_wide = {r[WIDTH-1], t};
    assign ge     = t_wide >= {1'b0, d};
    assign r_next = ge ? (t - d) : t;

endmodule

// File: rtl/mips_mod_unit.sv
// Sequential unsigned modulo unit: one remainder bit per clock.
module mips_mod_unit
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = MOD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

    mod_state_t       state;
    mod_state_t       nxt;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] r_next;
    logic             b_zero;

    assign b_zero = (b == '0);
    assign busy   = (state != IDLE);
    assign done   = (state == DONE);

    mod_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r),
        .qbit   (q[WIDTH-1]),
        .d      (d),
        .r_next (r_next)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: begin
                if (start) nxt = b_zero ? DONE : CALC;
            end
            CALC: begin
                if (cnt == '0) nxt = DONE;
            end
            DONE: nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            r        <= '0;
            q        <= '0;
            d        <= '0;
            cnt      <= '0;
            result   <= '0;
            div_zero <= 1'b0;
        end else begin
            state <= nxt;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        r   <= '0;
                        q   <= a;
                        d   <= b;
                        cnt <= CNT_INIT;
                        // Divide-by-zero: remainder is the dividend.
                        if (b_zero) begin
                            result   <= a;
                            div_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r   <= r_next;
                    q   <= q << 1;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result   <= r_next;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
